// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES-128 round orchestrator.
// Only a 128-bit state/key width is supported.
package aes_pkg;

    localparam int AES_WIDTH      = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_ROUND_W    = 4;

    localparam logic [AES_ROUND_W-1:0] AES_LAST_ROUND = AES_ROUND_W'(AES_NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_state_e;

endpackage

// File: rtl/aes_round_key_mux.sv
// Selects the pre-expanded round key for rounds 1..10.
// Round index 0 and any index above 10 select an all-zero key.
module aes_round_key_mux
    import aes_pkg::*;
#(
    parameter int WIDTH = AES_WIDTH
) (
    input  logic [AES_ROUND_W-1:0] round,
    input  logic [WIDTH-1:0]       key_1_i,
    input  logic [WIDTH-1:0]       key_2_i,
    input  logic [WIDTH-1:0]       key_3_i,
    input  logic [WIDTH-1:0]       key_4_i,
    input  logic [WIDTH-1:0]       key_5_i,
    input  logic [WIDTH-1:0]       key_6_i,
    input  logic [WIDTH-1:0]       key_7_i,
    input  logic [WIDTH-1:0]       key_8_i,
    input  logic [WIDTH-1:0]       key_9_i,
    input  logic [WIDTH-1:0]       key_10_i,
    output logic [WIDTH-1:0]       key_o
);

    always_comb begin
        // NOTE: the default assignment before the case keeps every path driven, so no latch is inferred.
        key_o = '0;
        case (round)
            4'd1:    key_o = key_1_i;
            4'd2:    key_o = key_2_i;
            4'd3:    key_o = key_3_i;
            4'd4:    key_o = key_4_i;
            4'd5:    key_o = key_5_i;
            4'd6:    key_o = key_6_i;
            4'd7:    key_o = key_7_i;
            4'd8:    key_o = key_8_i;
            4'd9:    key_o = key_9_i;
            4'd10:   key_o = key_10_i;
            default: key_o = '0;
        endcase
    end

endmodule

// File: rtl/aes_round_orchestrator.sv
// Sequences one AES-128 encryption through an external combinational round unit:
// initial AddRoundKey, then rounds 1..10 fed back through data_feedback_i.
module aes_round_orchestrator
    import aes_pkg::*;
#(
    parameter int WIDTH = AES_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] data_feedback_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic [WIDTH-1:0] key_1_i,
    input  logic [WIDTH-1:0] key_2_i,
    input  logic [WIDTH-1:0] key_3_i,
    input  logic [WIDTH-1:0] key_4_i,
    input  logic [WIDTH-1:0] key_5_i,
    input  logic [WIDTH-1:0] key_6_i,
    input  logic [WIDTH-1:0] key_7_i,
    input  logic [WIDTH-1:0] key_8_i,
    input  logic [WIDTH-1:0] key_9_i,
    input  logic [WIDTH-1:0] key_10_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] data_final_o,
    output logic [WIDTH-1:0] key_o,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    aes_state_e             state;
    aes_state_e             state_next;
    logic [AES_ROUND_W-1:0] round;
    logic [WIDTH-1:0]       state_reg;
    logic [WIDTH-1:0]       round_key;

    aes_round_key_mux #(
        .WIDTH (WIDTH)
    ) u_key_mux (
        .round    (round),
        .key_1_i  (key_1_i),
        .key_2_i  (key_2_i),
        .key_3_i  (key_3_i),
        .key_4_i  (key_4_i),
        .key_5_i  (key_5_i),
        .key_6_i  (key_6_i),
        .key_7_i  (key_7_i),
        .key_8_i  (key_8_i),
        .key_9_i  (key_9_i),
        .key_10_i (key_10_i),
        .key_o    (round_key)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: the whole datapath is reset (not just the FSM) so every output reads 0 during reset and after an abort.
        if (!rst_n_i) begin
            state        <= IDLE;
            round        <= '0;
            state_reg    <= '0;
            data_final_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        state_reg <= data_i ^ key_i;
                        round     <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= data_feedback_i;
                    if (round == AES_LAST_ROUND) begin
                        data_final_o <= data_feedback_i;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    round <= '0;
                end
                default: begin
                    round <= '0;
                end
            endcase
        end
    end

    // The round unit recognises the final round purely as the 10th data_valid cycle.
    always_comb begin
        state_next = state;
        data_o     = state_reg;
        key_o      = '0;
        data_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy       = 1'b1;
                data_valid = 1'b1;
                key_o      = round_key;
                if (round == AES_LAST_ROUND) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_orchestrator.sv
// Scoreboard bench: the bench plays the round unit (zero, XOR loopback or a real AES round)
// and checks every round presentation and each ciphertext against a behavioural model.
module tb_aes_round_orchestrator;

    logic         clk_i;
    logic         rst_n_i;
    logic         start;
    logic [127:0] data_i;
    logic [127:0] data_feedback_i;
    logic [127:0] rk [0:10];
    logic [127:0] data_o;
    logic [127:0] data_final_o;
    logic [127:0] key_o;
    logic         data_valid;
    logic         busy;
    logic         done;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
    } round_exp_t;

    round_exp_t   rq[$];
    logic [127:0] fq[$];

    int       vectors;
    int       miscompares;
    int       mode;       // 0: feedback tied to 0, 1: XOR loopback, 2: AES round
    int       dv_cnt;
    logic [3:0] vcnt;

    aes_round_orchestrator dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start           (start),
        .data_i          (data_i),
        .data_feedback_i (data_feedback_i),
        .key_i           (rk[0]),
        .key_1_i         (rk[1]),
        .key_2_i         (rk[2]),
        .key_3_i         (rk[3]),
        .key_4_i         (rk[4]),
        .key_5_i         (rk[5]),
        .key_6_i         (rk[6]),
        .key_7_i         (rk[7]),
        .key_8_i         (rk[8]),
        .key_9_i         (rk[9]),
        .key_10_i        (rk[10]),
        .data_o          (data_o),
        .data_final_o    (data_final_o),
        .key_o           (key_o),
        .data_valid      (data_valid),
        .busy            (busy),
        .done            (done)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input bit fin);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i] ^ k[127-8*i -: 8];
        return res;
    endfunction

    function automatic logic [127:0] model_step(input int m, input logic [127:0] st,
                                                input logic [127:0] k, input bit fin);
        case (m)
            0:       return '0;
            1:       return st ^ k;
            default: return aes_round(st, k, fin);
        endcase
    endfunction

    // AES-128 key expansion into rk[0..10].
    task automatic set_aes_keys(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- round unit model ----------------
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        vcnt <= 4'd0;
        else if (data_valid) vcnt <= (vcnt == 4'd9) ? 4'd0 : vcnt + 4'd1;
    end

    always_comb begin
        data_feedback_i = model_step(mode, data_o, key_o, vcnt == 4'd9);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a round or a completion.
    initial begin
        round_exp_t e;
        dv_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                dv_cnt = 0;
            end else begin
                if (data_valid) begin
                    dv_cnt++;
                    if (rq.size() == 0) begin
                        fail_now("round_unexpected");
                    end else begin
                        e = rq.pop_front();
                        check("round_data_o", data_o, e.data);
                        check("round_key_o", key_o, e.key);
                        check("round_busy", 128'(busy), 128'd1);
                    end
                end
                if (done) begin
                    check("dv_count", 128'(dv_cnt), 128'd10);
                    dv_cnt = 0;
                    if (fq.size() == 0) begin
                        fail_now("done_unexpected");
                    end else begin
                        check("data_final_o", data_final_o, fq.pop_front());
                    end
                    check("done_busy_valid", {126'd0, busy, data_valid}, 128'd0);
                    check("done_key_o", key_o, 128'd0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic abort_and_recover();
        #2 rst_n_i = 1'b0;
        #1;
        check("abort_data_o", data_o, 128'd0);
        check("abort_data_final_o", data_final_o, 128'd0);
        check("abort_key_o", key_o, 128'd0);
        check("abort_flags", {125'd0, busy, done, data_valid}, 128'd0);
        rq.delete();
        fq.delete();
        start = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic run(input int m, input logic [127:0] pt, input int restart_at,
                       input int abort_at, input bit has_golden, input logic [127:0] golden);
        logic [127:0] st;
        logic [127:0] exp_final;
        int           cyc;
        bit           got_done;
        round_exp_t   e;
        mode   = m;
        data_i = pt;
        st = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            e.data = st;
            e.key  = rk[r];
            rq.push_back(e);
            st = model_step(m, st, rk[r], r == 10);
        end
        exp_final = has_golden ? golden : st;
        fq.push_back(exp_final);

        @(negedge clk_i);
        start    = 1'b1;
        cyc      = 0;
        got_done = 1'b0;
        while (cyc < 40 && !got_done) begin
            @(negedge clk_i);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == abort_at) begin
                abort_and_recover();
                return;
            end
            got_done = done;
        end
        start = 1'b0;
        check("latency", 128'(cyc), 128'd11);
        if (!got_done) begin
            rq.delete();
            fq.delete();
        end
        @(negedge clk_i);
        check("idle_flags", {125'd0, busy, done, data_valid}, 128'd0);
        check("idle_key_o", key_o, 128'd0);
        check("idle_data_o", data_o, exp_final);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] k0;
        logic [127:0] c1_pt;
        logic [127:0] c1_key;
        logic [127:0] c1_ct;
        int           m;
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        start       = 1'b0;
        data_i      = '0;
        for (int r = 0; r <= 10; r++) rk[r] = '0;
        c1_pt  = 128'h00112233445566778899aabbccddeeff;
        c1_key = 128'h000102030405060708090a0b0c0d0e0f;
        c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        // Reset held for two cycles: everything reads zero.
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_data_o", data_o, 128'd0);
        check("reset_data_final_o", data_final_o, 128'd0);
        check("reset_key_o", key_o, 128'd0);
        check("reset_flags", {125'd0, busy, done, data_valid}, 128'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Tied-off feedback: first round shows data_i^key_i, ciphertext is zero.
        rk[0] = c1_key;
        for (int r = 1; r <= 10; r++) rk[r] = rand128();
        run(0, c1_pt, 0, 0, 1'b1, 128'd0);

        // FIPS-197 C.1 through the AES round model.
        set_aes_keys(c1_key);
        run(2, c1_pt, 0, 0, 1'b1, c1_ct);

        // XOR loopback with random keys.
        rk[0] = rand128();
        for (int r = 1; r <= 10; r++) rk[r] = rand128();
        run(1, rand128(), 0, 0, 1'b0, '0);

        // Second start during round 5 is ignored.
        rk[0] = rand128();
        for (int r = 1; r <= 10; r++) rk[r] = rand128();
        run(1, rand128(), 5, 0, 1'b0, '0);

        // Reset during round 5 aborts; a fresh C.1 run afterwards still works.
        set_aes_keys(c1_key);
        run(2, c1_pt, 0, 5, 1'b0, '0);
        run(2, c1_pt, 0, 0, 1'b1, c1_ct);

        // Randomised runs across all round-unit behaviours.
        for (int n = 0; n < 8; n++) begin
            m  = int'($urandom_range(0, 2));
            pt = rand128();
            k0 = rand128();
            if (m == 2) begin
                set_aes_keys(k0);
            end else begin
                rk[0] = k0;
                for (int r = 1; r <= 10; r++) rk[r] = rand128();
            end
            run(m, pt, 0, 0, 1'b0, '0);
        end

        if (rq.size() != 0 || fq.size() != 0) fail_now("scoreboard_leftover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
